// File: rtl/keypad_if.sv
// keypad_if: CPU bus bundle for the keypad register block.
// Ports: bus_write/bus_read strobes, bus_address_in (24b), bus_data_in (8b) from the CPU,
//        bus_data_out (8b) back from the peripheral.
interface keypad_if;
    logic        bus_write;
    logic        bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    modport master (output bus_write, bus_read, bus_address_in, bus_data_in, input bus_data_out);
    modport slave  (input bus_write, bus_read, bus_address_in, bus_data_in, output bus_data_out);
endinterface

// File: rtl/keypad.sv
// keypad: synchronizes and debounces 8 keys, raises per-key press/release interrupt pulses,
//         and exposes KEY_EDGE (0x2050, R/W) and KEY_STATE (0x2052, RO, active-low) registers.
// Ports: clk, reset (sync, active-high), bus (keypad_if.slave), keys_in[7:0] raw levels
//        (1 = pressed), irqs[7:0] one-cycle interrupt pulses.
// Config: define KEYPAD_DEBOUNCE_EN to build the per-key debounce counters; otherwise the
//         synchronizer output is used directly as the stable key state.
module keypad #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    keypad_if.slave    bus,
    input  logic [7:0] keys_in,
    output logic [7:0] irqs
);
    localparam logic [23:0] ADDR_EDGE  = 24'h002050;
    localparam logic [23:0] ADDR_STATE = 24'h002052;

    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_cfg
        $error("keypad: DEBOUNCE_CYCLES out of range 1..65535");
    end

    logic [7:0] sync1_q, sync2_q;
    logic [7:0] key_edge_q, key_edge_d;
    logic [7:0] prev_q;
    logic [7:0] irqs_q, irqs_d;
    logic [7:0] stable;

`ifdef KEYPAD_DEBOUNCE_EN
    // Acceptance happens on the cycle the count would reach DEBOUNCE_CYCLES.
    localparam logic [15:0] LAST = 16'(DEBOUNCE_CYCLES - 1);
    logic [7:0]  stable_q, stable_d;
    logic [15:0] cnt_q [8];
    logic [15:0] cnt_d [8];
    assign stable = stable_q;
`else
    assign stable = sync2_q;
`endif

    always_comb begin
        key_edge_d = (bus.bus_write && bus.bus_address_in == ADDR_EDGE) ? bus.bus_data_in : key_edge_q;
        // Direction uses the register value held before any same-cycle write.
        irqs_d     = (stable & ~prev_q & ~key_edge_q) | (~stable & prev_q & key_edge_q);
`ifdef KEYPAD_DEBOUNCE_EN
        stable_d   = stable_q;
        for (int i = 0; i < 8; i++) begin
            cnt_d[i] = (sync2_q[i] == stable_q[i] || cnt_q[i] == LAST) ? 16'd0 : cnt_q[i] + 16'd1;
            if (sync2_q[i] != stable_q[i] && cnt_q[i] == LAST) stable_d[i] = sync2_q[i];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            key_edge_q <= '0;
            prev_q     <= '0;
            irqs_q     <= '0;
`ifdef KEYPAD_DEBOUNCE_EN
            stable_q   <= '0;
            for (int i = 0; i < 8; i++) cnt_q[i] <= '0;
`endif
        end else begin
            sync1_q    <= keys_in;
            sync2_q    <= sync1_q;
            key_edge_q <= key_edge_d;
            prev_q     <= stable;
            irqs_q     <= irqs_d;
`ifdef KEYPAD_DEBOUNCE_EN
            stable_q   <= stable_d;
            for (int i = 0; i < 8; i++) cnt_q[i] <= cnt_d[i];
`endif
        end
    end

    assign irqs = irqs_q;
    assign bus.bus_data_out = !bus.bus_read                      ? 8'h00 :
                              bus.bus_address_in == ADDR_EDGE    ? key_edge_q :
                              bus.bus_address_in == ADDR_STATE   ? ~stable : 8'h00;
endmodule

// File: tb/tb_keypad.sv
// tb_keypad: scoreboard bench for keypad; stimulus queues expected irq pulses and read data,
//            a negedge monitor pops and compares whenever the DUT presents them.
module tb_keypad;
    localparam int DB = 4;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int LAT = 3 + DB;
`else
    localparam int LAT = 3;
`endif

    logic       clk = 0;
    logic       reset = 1;
    logic [7:0] keys_in = 8'h00;
    logic [7:0] irqs;
    logic       probe = 0;
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;

    typedef struct {int cyc; logic [7:0] val;} irq_t;
    irq_t       irq_q[$];
    logic [7:0] rd_q[$];
    irq_t       m_e;
    logic [7:0] m_rd;

    keypad_if bus();
    keypad #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset(reset), .bus(bus), .keys_in(keys_in), .irqs(irqs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (irqs !== 8'h00) begin
            checks++;
            if (irq_q.size() == 0) begin
                errors++;
                $display("FAIL irq_unexpected cyc=%0d got=%02h expected=00", cyc, irqs);
            end else begin
                m_e = irq_q.pop_front();
                if (m_e.val !== irqs || m_e.cyc != cyc) begin
                    errors++;
                    $display("FAIL irq cyc=%0d got=%02h expected=%02h at cyc %0d", cyc, irqs, m_e.val, m_e.cyc);
                end
            end
        end
        if (probe) begin
            checks++;
            m_rd = rd_q.size() ? rd_q.pop_front() : 8'hxx;
            if (bus.bus_data_out !== m_rd) begin
                errors++;
                $display("FAIL read addr=%06h rd=%0b got=%02h expected=%02h", bus.bus_address_in, bus.bus_read, bus.bus_data_out, m_rd);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_irq(input int dly, input logic [7:0] v);
        irq_t e;
        e.cyc = cyc + dly;
        e.val = v;
        irq_q.push_back(e);
    endtask

    task automatic wr(input logic [23:0] a, input logic [7:0] d);
        tick(1);
        bus.bus_write = 1;
        bus.bus_address_in = a;
        bus.bus_data_in = d;
        tick(1);
        bus.bus_write = 0;
    endtask

    task automatic rd(input logic [23:0] a, input logic en, input logic [7:0] exp);
        tick(1);
        bus.bus_read = en;
        bus.bus_address_in = a;
        rd_q.push_back(exp);
        probe = 1;
        @(negedge clk);
        #1;
        probe = 0;
        bus.bus_read = 0;
    endtask

    initial begin
        bus.bus_write = 0;
        bus.bus_read = 0;
        bus.bus_address_in = '0;
        bus.bus_data_in = '0;
        tick(3);
        checks++;
        if (irqs !== 8'h00) begin
            errors++;
            $display("FAIL reset_irqs got=%02h expected=00", irqs);
        end
        reset = 0;
        rd(24'h002052, 1, 8'hFF);
        rd(24'h002050, 1, 8'h00);
        // press A, then release (press-only direction)
        tick(1);
        keys_in = 8'h01;
        expect_irq(LAT, 8'h01);
        tick(LAT + 2);
        rd(24'h002052, 1, 8'hFE);
        keys_in = 8'h00;
        tick(LAT + 3);
        // 3-cycle glitch on B
        tick(1);
        keys_in = 8'h02;
`ifndef KEYPAD_DEBOUNCE_EN
        expect_irq(LAT, 8'h02);
`endif
        tick(3);
        keys_in = 8'h00;
        tick(LAT + 3);
        rd(24'h002052, 1, 8'hFF);
        // Power configured for release interrupt
        wr(24'h002050, 8'h80);
        rd(24'h002050, 1, 8'h80);
        tick(1);
        keys_in = 8'h80;
        tick(LAT + 3);
        keys_in = 8'h00;
        expect_irq(LAT, 8'h80);
        tick(LAT + 3);
        // KEY_STATE is read-only
        wr(24'h002052, 8'hAA);
        rd(24'h002050, 1, 8'h80);
        rd(24'h002052, 1, 8'hFF);
        wr(24'h002050, 8'h00);
        // Up and Down together
        tick(1);
        keys_in = 8'h18;
        expect_irq(LAT, 8'h18);
        tick(LAT + 3);
        keys_in = 8'h00;
        tick(LAT + 3);
        // reset mid-debounce with Left held
        tick(1);
        keys_in = 8'h20;
        tick(2);
        reset = 1;
        tick(2);
        reset = 0;
        expect_irq(LAT, 8'h20);
        tick(LAT + 3);
        rd(24'h002052, 1, 8'hDF);
        keys_in = 8'h00;
        tick(LAT + 3);
        // decode: unselected address and no read strobe both return zero
        wr(24'h002050, 8'h5A);
        rd(24'h002050, 0, 8'h00);
        rd(24'h002051, 1, 8'h00);
        rd(24'h002050, 1, 8'h5A);
        tick(5);
        checks++;
        if (irq_q.size() != 0) begin
            errors++;
            $display("FAIL irq_missing pending=%0d expected=0", irq_q.size());
        end
        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL read_missing pending=%0d expected=0", rd_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
